dmem_access_ctrl: RTL and testbench

Sequences every load/store of the single-cycle core against a data memory with variable latency and a request/ready/response handshake. While an access is in flight it stalls the core, which holds PC and suppresses RegWrite. It forms byte enables and lane-replicated store data, and sign- or zero-extends load data. Misaligned, illegal and timed-out accesses are reported as faults. It sits between the decoder/ALU outputs and the data memory port, replacing the direct combinational memory path.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/dmem_lane_fmt.sv | 73 +++++++
 rtl/dmem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory access path.
// State encoding, fault causes and load/store funct3 codes.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } dm_state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: store byte enables/replication,
// load extraction/extension, and access legality flags.
module dmem_lane_fmt
    import cpu_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        shifted  = rdata >> {off, 3'b000};
        byte_s   = shifted[7:0];
        half_s   = off[1] ? rdata[31:16] : rdata[15:0];
        be       = 4'b1111;
        st_data  = wdata;
        ld_data  = rdata;
        misalign = 1'b0;
        illegal  = 1'b0;

        if (is_load && is_store) begin
            illegal = 1'b1;
        end else if (is_load) begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end else if (is_store) begin
            illegal = (funct3 >= 3'd3);
        end

        case (funct3[1:0])
            2'b01:   misalign = off[0];
            2'b10:   misalign = (off != 2'b00);
            default: misalign = 1'b0;
        endcase

        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be      = 4'b0001 << off;
                    st_data = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be      = 4'b0011 << off;
                    st_data = {2{wdata[15:0]}};
                end
                default: begin
                    be      = 4'b1111;
                    st_data = wdata;
                end
            endcase
        end

        case (funct3)
            F3_B:    ld_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ld_data = {24'h0, byte_s};
            F3_H:    ld_data = {{16{half_s[15]}}, half_s};
            F3_HU:   ld_data = {16'h0, half_s};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences core loads/stores against a variable-latency data memory,
// stalling the core while an access is in flight and reporting faults.
module dmem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    dm_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_ld_q, is_ld_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] ld_data_q, ld_data_d;

    logic        idle;
    logic        fmt_ld, fmt_st;
    logic [2:0]  fmt_f3;
    logic [1:0]  fmt_off;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_st_data, fmt_ld_data;
    logic        fmt_mis, fmt_ill;

    // In IDLE the formatter checks the live request; afterwards the latched one.
    assign idle    = (state_q == S_IDLE);
    assign fmt_ld  = idle ? mem_read : is_ld_q;
    assign fmt_st  = idle ? mem_write : !is_ld_q;
    assign fmt_f3  = idle ? funct3 : f3_q;
    assign fmt_off = idle ? addr[1:0] : addr_q[1:0];

    dmem_lane_fmt u_fmt (
        .is_load  (fmt_ld),
        .is_store (fmt_st),
        .funct3   (fmt_f3),
        .off      (fmt_off),
        .wdata    (wdata_q),
        .rdata    (dm_rdata),
        .be       (fmt_be),
        .st_data  (fmt_st_data),
        .ld_data  (fmt_ld_data),
        .misalign (fmt_mis),
        .illegal  (fmt_ill)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        f3_d      = f3_q;
        wdata_d   = wdata_q;
        is_ld_d   = is_ld_q;
        cause_d   = cause_q;
        ld_data_d = ld_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    is_ld_d = mem_read;
                    if (fmt_ill) begin
                        cause_d = FC_ILLEGAL;
                        state_d = S_DONE;
                    end else if (fmt_mis) begin
                        cause_d = FC_MISALIGN;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr;
                        f3_d    = funct3;
                        wdata_d = wdata;
                        cause_d = FC_NONE;
                        cnt_d   = 8'd0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // A store accepted on the limit cycle still completes.
                if (dm_ready && !is_ld_q) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cause_d = FC_TIMEOUT;
                    state_d = S_DONE;
                end else if (dm_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (dm_rvalid) begin
                    ld_data_d = fmt_ld_data;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cause_d = FC_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= 32'd0;
            f3_q      <= 3'd0;
            wdata_q   <= 32'd0;
            is_ld_q   <= 1'b0;
            cause_q   <= FC_NONE;
            ld_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            f3_q      <= f3_d;
            wdata_q   <= wdata_d;
            is_ld_q   <= is_ld_d;
            cause_q   <= cause_d;
            ld_data_q <= ld_data_d;
        end
    end

    always_comb begin
        stall       = !reset && ((idle && (mem_read || mem_write))
                      || (state_q == S_REQ) || (state_q == S_RESP));
        dm_req      = (state_q == S_REQ);
        dm_we       = dm_req && !is_ld_q;
        dm_addr     = dm_req ? {addr_q[31:2], 2'b00} : 32'd0;
        dm_be       = dm_req ? fmt_be : 4'b0000;
        dm_wdata    = dm_we ? fmt_st_data : 32'd0;
        load_data   = ld_data_q;
        load_valid  = (state_q == S_DONE) && is_ld_q && (cause_q == FC_NONE);
        fault       = (state_q == S_DONE) && (cause_q != FC_NONE);
        fault_cause = fault ? cause_q : FC_NONE;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a byte-level memory model.
module tb_dmem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, fault;
    logic [1:0]  fault_cause;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ready, dm_rvalid;
    logic [31:0] dm_rdata;

    dmem_access_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .fault(fault),
        .fault_cause(fault_cause),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } req_t;
    typedef struct {
        logic        is_fault;
        logic [1:0]  cause;
        logic [31:0] data;
    } rsp_t;
    typedef struct {
        int rd;
        int vd;
    } dly_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    dly_t dly_q[$];

    logic [31:0] ram [256];
    logic [7:0]  refm [1024];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        ram[a[9:2]] = v;
        for (int k = 0; k < 4; k++)
            refm[{a[9:2], 2'(k)}] = v[8*k +: 8];
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a,
                                             input logic [2:0] f3);
        logic [31:0] v;
        int n;
        n = acc_size(f3);
        v = 0;
        for (int k = 0; k < n; k++)
            v[8*k +: 8] = refm[10'(a[9:0] + 10'(k))];
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] d);
        for (int k = 0; k < acc_size(f3); k++)
            refm[10'(a[9:0] + 10'(k))] = d[8*k +: 8];
    endtask

    // Memory responder: timing per access comes from dly_q.
    initial begin
        dly_t d;
        logic ld, acc, ok;
        logic [31:0] a;
        int j;
        bit fin;
        dm_ready = 0;
        dm_rvalid = 0;
        dm_rdata = 0;
        a = 0;
        forever begin
            @(posedge clk);
            #2;
            if (dm_req && !reset) begin
                d = (dly_q.size() != 0) ? dly_q.pop_front() : '{0, 0};
                ld = !dm_we;
                j = 0;
                fin = 0;
                acc = 0;
                ok = 0;
                while (!fin) begin
                    dm_ready = (j == d.rd);
                    if (j == d.rd) begin
                        a = dm_addr;
                        acc = 1;
                        if (!ld)
                            for (int k = 0; k < 4; k++)
                                if (dm_be[k])
                                    ram[a[9:2]][8*k +: 8] = dm_wdata[8*k +: 8];
                    end
                    dm_rvalid = ld && acc && (j == d.rd + 1 + d.vd);
                    dm_rdata = dm_rvalid ? ram[a[9:2]] : $urandom;
                    if (!ld && j == d.rd) fin = 1;
                    if (dm_rvalid) begin fin = 1; ok = 1; end
                    if (j == TMO - 1) fin = 1;
                    j++;
                    @(posedge clk);
                    #2;
                end
                dm_ready = 0;
                dm_rvalid = 0;
                if (ld && acc && !ok) begin
                    dm_rvalid = 1;
                    dm_rdata = $urandom;
                    @(posedge clk);
                    #2;
                    dm_rvalid = 0;
                end
            end
        end
    end

    // Monitor: handshakes and result pulses against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (dm_req && dm_ready) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_addr", dm_addr, r.addr);
                    chk("req_we", 32'(dm_we), 32'(r.we));
                    chk("req_be", 32'(dm_be), 32'(r.be));
                    if (r.we) chk("req_wdata", dm_wdata, r.wd);
                end
            end
            if (load_valid || fault) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {load_valid, fault}, 0);
                end else begin
                    rsp_t p;
                    p = rsp_q.pop_front();
                    chk("rsp_kind", 32'({fault, load_valid}),
                        32'({p.is_fault, !p.is_fault}));
                    if (p.is_fault) chk("fault_cause", 32'(fault_cause), 32'(p.cause));
                    else chk("load_data", load_data, p.data);
                end
            end
        end
    end

    int last_req_cyc;
    int last_stall;

    task automatic issue(input bit rd_i, input bit wr_i, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int rdl, input int vdl);
        bit ill, mis, acc, done;
        int cycles, exp_stall, exp_reqc, stall_cnt, reqc, badf, first_req;
        logic [3:0] ebe;
        logic [31:0] ewd;
        ill = (rd_i && wr_i) || (rd_i && (f3 == 3 || f3 == 6 || f3 == 7))
              || (wr_i && f3 >= 3);
        mis = (a % acc_size(f3)) != 0;
        ebe = 4'b1111;
        ewd = wd;
        if (wr_i && !ill) begin
            ebe = 0;
            for (int k = 0; k < acc_size(f3); k++)
                ebe[int'(a[1:0]) + k] = 1'b1;
            if (acc_size(f3) == 1) ewd = {4{wd[7:0]}};
            if (acc_size(f3) == 2) ewd = {2{wd[15:0]}};
        end
        exp_reqc = 0;
        if (ill) begin
            rsp_q.push_back('{1'b1, 2'b11, 32'd0});
            exp_stall = 1;
        end else if (mis) begin
            rsp_q.push_back('{1'b1, 2'b01, 32'd0});
            exp_stall = 1;
        end else begin
            cycles = rdl + 1 + (rd_i ? vdl + 1 : 0);
            acc = rdl < TMO;
            dly_q.push_back('{rdl, vdl});
            if (acc) req_q.push_back('{a & ~32'd3, wr_i, ebe, ewd});
            exp_reqc = acc ? rdl + 1 : TMO;
            if (cycles > TMO) begin
                rsp_q.push_back('{1'b1, 2'b10, 32'd0});
                exp_stall = TMO + 1;
            end else begin
                exp_stall = cycles + 1;
                if (wr_i) ref_store(a, f3, wd);
                else rsp_q.push_back('{1'b0, 2'b00, ref_load(a, f3)});
            end
        end
        @(posedge clk);
        #1;
        mem_read = rd_i;
        mem_write = wr_i;
        funct3 = f3;
        addr = a;
        wdata = wd;
        stall_cnt = 0;
        reqc = 0;
        badf = 0;
        first_req = -1;
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (dm_req) begin
                reqc++;
                if (first_req < 0) first_req = cyc;
                if (dm_addr !== (a & ~32'd3) || dm_be !== ebe
                    || (wr_i && dm_wdata !== ewd)) badf++;
            end
            if (!stall) done = 1;
        end
        mem_read = 0;
        mem_write = 0;
        chk("access_finished", 32'(done), 1);
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("req_cycles", reqc, exp_reqc);
        chk("req_fields", badf, 0);
        last_req_cyc = first_req;
        last_stall = stall_cnt;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no-finish want finish");
        $fatal(1);
    end

    initial begin
        int c0, s0;
        reset = 1;
        mem_read = 0;
        mem_write = 0;
        funct3 = 0;
        addr = 0;
        wdata = 0;
        for (int w = 0; w < 256; w++) set_word(32'(w) << 2, $urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 32'({stall, dm_req, dm_we, load_valid, fault,
            fault_cause}), 0);
        chk("reset_bus", dm_addr | dm_wdata | load_data | 32'(dm_be), 0);
        @(posedge clk);
        #1;
        reset = 0;

        set_word(32'h1000, 32'h80FF_FF12);
        issue(1, 0, 3'd0, 32'h1003, 0, 0, 0);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        issue(0, 1, 3'd1, 32'h22, 32'h1234_ABCD, 2, 0);
        chk("sh_ram", ram[8'h08] & 32'hFFFF_0000, 32'hABCD_0000);
        issue(1, 0, 3'd2, 32'h06, 0, 0, 0);
        issue(1, 0, 3'd2, 32'h40, 0, 0, 20);
        issue(1, 1, 3'd2, 32'h40, 0, 0, 0);
        issue(0, 1, 3'd5, 32'h40, 0, 0, 0);
        issue(0, 1, 3'd2, 32'h44, 32'h5555_AAAA, 3, 0);
        issue(0, 1, 3'd2, 32'h48, 32'h1111_2222, 4, 0);

        // Reset while the load sits in RESP.
        dly_q.push_back('{0, 2});
        req_q.push_back('{32'h40, 1'b0, 4'b1111, 32'd0});
        @(posedge clk);
        #1;
        mem_read = 1;
        funct3 = 3'd2;
        addr = 32'h40;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1;
        mem_read = 0;
        @(negedge clk);
        chk("stall_in_reset", 32'(stall), 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("post_reset_ctrl", 32'({stall, dm_req, dm_we, load_valid, fault,
            fault_cause}), 0);
        chk("post_reset_bus", dm_addr | dm_wdata | load_data | 32'(dm_be), 0);
        repeat (6) @(posedge clk);
        set_word(32'h0, 32'h0000_F000);
        issue(1, 0, 3'd4, 32'h1, 0, 0, 0);
        chk("lbu_data", load_data, 32'h0000_00F0);

        issue(0, 1, 3'd2, 32'h80, 32'hCAFE_F00D, 0, 0);
        c0 = last_req_cyc;
        s0 = last_stall;
        issue(1, 0, 3'd2, 32'h80, 0, 0, 0);
        chk("b2b_req_gap", last_req_cyc - c0, 3);
        chk("b2b_stall", s0 + last_stall, 5);
        chk("b2b_data", load_data, 32'hCAFE_F00D);

        for (int i = 0; i < 200; i++) begin
            int r;
            bit rd_i, wr_i;
            r = $urandom_range(0, 9);
            rd_i = (r <= 4) || (r == 9);
            wr_i = (r >= 5);
            issue(rd_i, wr_i, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom_range(0, 4), $urandom_range(0, 3));
        end

        repeat (10) @(posedge clk);
        chk("queues_drained", req_q.size() + rsp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
